// File: rtl/bus_dest_decoder.sv
// rtl/bus_dest_decoder.sv - one-hot destination write strobe decoder with transfer handshake
module bus_dest_decoder #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        dest_code,
    input  logic [DATA_W-1:0] bus_data,
    output logic [23:0]       dest_en,
    output logic [DATA_W-1:0] dest_data,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  xfer_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [4:0] NUM_DEST = 5'd24;

    state_t state_q;
    state_t state_next;
    // First cycle of ERR is a wait slot so err lands at the same latency as done.
    logic   err_wait_q;
    logic   handshake;
    logic   code_legal;

    assign handshake  = req_valid && req_ready;
    assign code_legal = (dest_code < NUM_DEST);

    // Next-state decode; outputs below are registered from this look-ahead.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_next = code_legal ? STROBE : ERR;
                end
            end
            STROBE:  state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = err_wait_q ? ERR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and all registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            err_wait_q <= 1'b0;
            req_ready  <= 1'b1;
            dest_en    <= '0;
            dest_data  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            xfer_count <= '0;
        end else begin
            state_q    <= state_next;
            err_wait_q <= (state_q == IDLE) && (state_next == ERR);
            req_ready  <= (state_next == IDLE);
            done       <= (state_next == DONE);
            err        <= (state_q == ERR) && err_wait_q;
            if ((state_q == IDLE) && (state_next == STROBE)) begin
                dest_en   <= 24'd1 << dest_code;
                dest_data <= bus_data;
            end else begin
                dest_en   <= '0;
            end
            if (state_next == DONE) begin
                xfer_count <= xfer_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_dest_decoder.sv
// tb/tb_bus_dest_decoder.sv - table-driven self-checking bench for bus_dest_decoder
module tb_bus_dest_decoder;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        req_valid;
    logic [4:0]  dest_code;
    logic [31:0] bus_data;

    logic        req_ready;
    logic [23:0] dest_en;
    logic [31:0] dest_data;
    logic        done;
    logic        err;
    logic [15:0] xfer_count;

    logic        w_ready;
    logic [23:0] w_en;
    logic [31:0] w_data;
    logic        w_done;
    logic        w_err;
    logic [3:0]  w_count;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_count;
    logic [31:0] exp_data;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] data;
        logic [23:0] exp_en;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    always #5 clock = ~clock;

    bus_dest_decoder #(.DATA_W(32), .CNT_W(16)) u_dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .dest_code  (dest_code),
        .bus_data   (bus_data),
        .dest_en    (dest_en),
        .dest_data  (dest_data),
        .done       (done),
        .err        (err),
        .xfer_count (xfer_count)
    );

    bus_dest_decoder #(.DATA_W(32), .CNT_W(4)) u_wrap (
        .clock      (clock),
        .clear_n    (clear_n),
        .req_valid  (req_valid),
        .req_ready  (w_ready),
        .dest_code  (dest_code),
        .bus_data   (bus_data),
        .dest_en    (w_en),
        .dest_data  (w_data),
        .done       (w_done),
        .err        (w_err),
        .xfer_count (w_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 20) begin
            tick();
            k++;
        end
        check("ready_wait", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic xfer(input logic [4:0] code, input logic [31:0] data,
                        input logic [23:0] exp_en, input logic exp_err);
        wait_ready();
        req_valid = 1'b1;
        dest_code = code;
        bus_data  = data;
        tick();
        req_valid = 1'b0;
        dest_code = ~code;
        bus_data  = ~data;
        if (!exp_err) exp_data = data;
        check("strobe_en",    {40'd0, dest_en}, {40'd0, exp_en});
        check("strobe_data",  {32'd0, dest_data}, {32'd0, exp_data});
        check("strobe_ready", {63'd0, req_ready}, 64'd0);
        check("strobe_flags", {62'd0, done, err}, 64'd0);
        tick();
        if (!exp_err) exp_count = exp_count + 16'd1;
        check("end_en",    {40'd0, dest_en}, 64'd0);
        check("end_flags", {62'd0, done, err}, {62'd0, !exp_err, exp_err});
        check("end_data",  {32'd0, dest_data}, {32'd0, exp_data});
        check("end_count", {48'd0, xfer_count}, {48'd0, exp_count});
        check("wrap_count", {60'd0, w_count}, {60'd0, exp_count[3:0]});
        tick();
        check("back_ready", {63'd0, req_ready}, 64'd1);
        check("back_flags", {62'd0, done, err}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] walk;

        vecs[0] = '{5'd5,  32'h0000_1234, 24'h000020, 1'b0};
        vecs[1] = '{5'd27, 32'hDEAD_BEEF, 24'h000000, 1'b1};
        vecs[2] = '{5'd0,  32'hA5A5_A5A5, 24'h000001, 1'b0};
        vecs[3] = '{5'd23, 32'hFFFF_FFFF, 24'h800000, 1'b0};
        vecs[4] = '{5'd24, 32'h0000_0001, 24'h000000, 1'b1};
        vecs[5] = '{5'd31, 32'h0000_0002, 24'h000000, 1'b1};
        vecs[6] = '{5'd16, 32'h0BAD_F00D, 24'h010000, 1'b0};
        vecs[7] = '{5'd21, 32'h0000_0000, 24'h200000, 1'b0};

        clear_n   = 1'b0;
        req_valid = 1'b1;
        dest_code = 5'd3;
        bus_data  = 32'h1111_2222;
        exp_count = 16'd0;
        exp_data  = 32'd0;

        // Reset with a request pending: the request must be discarded.
        tick();
        tick();
        clear_n   = 1'b1;
        req_valid = 1'b0;
        check("rst_en",    {40'd0, dest_en}, 64'd0);
        check("rst_data",  {32'd0, dest_data}, 64'd0);
        check("rst_flags", {62'd0, done, err}, 64'd0);
        check("rst_count", {48'd0, xfer_count}, 64'd0);
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        tick();
        check("rst_drop_en",    {40'd0, dest_en}, 64'd0);
        check("rst_drop_ready", {63'd0, req_ready}, 64'd1);

        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i].code, vecs[i].data, vecs[i].exp_en, vecs[i].exp_err);
        end

        // Back-to-back sweep, request held high the whole time.
        walk = 24'h000001;
        req_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            wait_ready();
            dest_code = 5'(i);
            bus_data  = 32'h100 + 32'(i);
            tick();
            dest_code = 5'd31;
            exp_data  = 32'h100 + 32'(i);
            check("sweep_en",   {40'd0, dest_en}, {40'd0, walk});
            check("sweep_data", {32'd0, dest_data}, {32'd0, exp_data});
            tick();
            exp_count = exp_count + 16'd1;
            check("sweep_done", {62'd0, done, err}, 64'd2);
            tick();
            walk = walk << 1;
        end
        req_valid = 1'b0;
        check("sweep_count", {48'd0, xfer_count}, 64'd29);

        // Reset during STROBE of code 20.
        req_valid = 1'b1;
        dest_code = 5'd20;
        bus_data  = 32'h0000_0055;
        tick();
        req_valid = 1'b0;
        check("abort_strobe_en", {40'd0, dest_en}, 64'h100000);
        clear_n = 1'b0;
        tick();
        clear_n   = 1'b1;
        exp_count = 16'd0;
        exp_data  = 32'd0;
        check("abort_done",  {62'd0, done, err}, 64'd0);
        check("abort_count", {48'd0, xfer_count}, 64'd0);
        check("abort_data",  {32'd0, dest_data}, 64'd0);
        tick();
        check("abort_late",  {62'd0, done, err}, 64'd0);
        check("abort_late_count", {48'd0, xfer_count}, 64'd0);
        xfer(5'd0, 32'h0000_0077, 24'h000001, 1'b0);

        // Reset while an illegal code is in flight.
        req_valid = 1'b1;
        dest_code = 5'd27;
        tick();
        req_valid = 1'b0;
        clear_n   = 1'b0;
        tick();
        clear_n   = 1'b1;
        exp_count = 16'd0;
        exp_data  = 32'd0;
        check("err_abort_0", {62'd0, done, err}, 64'd0);
        tick();
        check("err_abort_1", {62'd0, done, err}, 64'd0);
        check("err_abort_count", {48'd0, xfer_count}, 64'd0);

        // Counter wrap on the 4-bit instance.
        for (int i = 0; i < 17; i++) begin
            xfer(5'(i % 24), 32'hC000_0000 + 32'(i), 24'd1 << (i % 24), 1'b0);
        end
        check("wrap_main", {48'd0, xfer_count}, 64'd17);
        check("wrap_small", {60'd0, w_count}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_dest_decoder.md
BUS_DEST_DECODER -- requirements
Module: bus_dest_decoder

Interface
REQ-001 Parameter DATA_W, default 32: width of the bus data word captured per transfer.
REQ-002 Parameter CNT_W, default 16: width of the completed-transfer counter.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 clear_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clock.
REQ-005 req_valid  input  1  requester has a destination write pending.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 dest_code  input  5  destination select code: 0-15 = R0-R15, 16 = HI, 17 = LO, 18 = ZHI, 19 = ZLO, 20 = PC, 21 = MDR, 22 = InPort, 23 = C.
REQ-008 bus_data  input  DATA_W  bus word to be written to the destination.
REQ-009 dest_en  output  24  one-hot destination write enable; bit k corresponds to dest_code k.
REQ-010 dest_data  output  DATA_W  captured bus word, held stable while dest_en is asserted.
REQ-011 done  output  1  one-cycle pulse on completion of a valid transfer.
REQ-012 err  output  1  one-cycle pulse on rejection of an out-of-range code (24-31).
REQ-013 xfer_count  output  CNT_W  number of completed valid transfers.

Function
REQ-014 The FSM SHALL have four states: IDLE, STROBE, DONE and ERR; all outputs SHALL be registered.
REQ-015 req_ready SHALL be 1 only in IDLE; a handshake occurs on an edge where req_valid=1 and req_ready=1.
REQ-016 IDLE, handshake, dest_code<24: capture dest_code and bus_data, then go to STROBE.
REQ-017 IDLE, handshake, dest_code>=24: capture nothing, leave dest_data unchanged, then go to ERR.
REQ-018 IDLE with no handshake: remain in IDLE with dest_en=0.
REQ-019 STROBE: dest_en SHALL have exactly bit dest_code set for exactly one cycle, with dest_data equal to the captured word; next state DONE.
REQ-020 DONE: done=1 for one cycle, dest_en=0, xfer_count increments by 1; next state IDLE.
REQ-021 ERR: err=1 for one cycle, dest_en=0, xfer_count unchanged; next state IDLE.
REQ-022 Latency: handshake at edge N; dest_en high during cycle N+1; done or err high during cycle N+2; req_ready returns to 1 in cycle N+3.
REQ-023 Maximum throughput SHALL be one transfer per 3 cycles; req_valid while req_ready=0 is ignored, and the requester holds its request.
REQ-024 dest_en SHALL never have more than one bit set; done and err SHALL never be asserted in the same cycle.
REQ-025 xfer_count SHALL wrap from 2^CNT_W-1 to 0 without flagging.
REQ-026 Changes on dest_code or bus_data after the handshake SHALL NOT affect dest_en or dest_data for that transfer.

Reset
REQ-027 clear_n=0 at a rising edge SHALL force the state to IDLE with dest_en=0, dest_data=0, done=0, err=0 and xfer_count=0; req_ready reads 1 once clear_n returns to 1.
REQ-028 Reset asserted in STROBE, DONE or ERR SHALL abort the transfer: no further dest_en, done or err pulse, and no count increment.
REQ-029 A handshake on the same edge as clear_n=0 SHALL be discarded.

Verification
REQ-030 Post-reset check: after reset, dest_en=0, dest_data=0, done=0, err=0, xfer_count=0 and req_ready=1.
REQ-031 Valid transfer: dest_code=5, bus_data=0x0000_1234 -> next cycle dest_en=0x000020 and dest_data=0x0000_1234; following cycle done=1 and xfer_count=1.
REQ-032 Full sweep: codes 0..23 issued back-to-back, each held until accepted -> dest_en walks 0x000001 through 0x800000, each one-hot for one cycle; final xfer_count=24.
REQ-033 Illegal code: dest_code=27 -> dest_en stays 0, err pulses in cycle N+2, xfer_count unchanged, dest_data unchanged.
REQ-034 Abort and reload: clear_n=0 during STROBE of code 20 -> no done pulse, xfer_count=0; then a new request for code 0 completes with dest_en=0x000001.
REQ-035 Wrap: with CNT_W=4, run 17 valid transfers -> xfer_count=1.
